prng_scheduler: RTL and testbench
=================================

PRNG_SCHEDULER -- requirements
Module: prng_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter WARMUP, default 32, meaning LFSR steps discarded after reset or reseed (1..255).
REQ-003 SHALL have parameter DEFAULT_SEED, default 32'hBDCA2C92, meaning LFSR reset and substitute seed.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  NREQ  level request per requester, one byte per grant.
REQ-007 SHALL have port gnt  output  NREQ  registered one-hot grant, one-cycle pulse per byte.
REQ-008 SHALL have port prn  output  8  registered random byte, valid only while gnt is nonzero.
REQ-009 SHALL have port seed_valid  input  1  reseed request.
REQ-010 SHALL have port seed  input  32  reseed value.
REQ-011 SHALL have port seed_ready  output  1  reseed accepted when high with seed_valid.
REQ-012 SHALL have port busy  output  1  high when not in SERVE.

Function
REQ-013 SHALL implement states LOAD, WARMUP, SERVE; busy = (state != SERVE); seed_ready = (state != LOAD).
REQ-014 LFSR step SHALL be a shift left by one, with new bit0 = XNOR of bits 31, 21, 1, 0.
REQ-015 Byte tap SHALL be prn[7:0] = {L[2], L[3], L[5], L[7], L[11], L[13], L[17], L[23]} (bit 7 first), taken from the pre-step value.
REQ-016 A seed handshake SHALL go to LOAD next cycle and load the seed into the LFSR, or DEFAULT_SEED if seed == 32'hFFFFFFFF (the lockup state).
REQ-017 LOAD SHALL last exactly one cycle, clear the warmup counter, and then go to WARMUP.
REQ-018 WARMUP SHALL step the LFSR every cycle for exactly WARMUP cycles with gnt = 0, then go to SERVE.
REQ-019 In SERVE, when req != 0 and there is no seed handshake, the block SHALL pick one requester round-robin, starting at last granted + 1 modulo NREQ.
REQ-020 The pick SHALL assert the matching gnt bit and prn on the next cycle and step the LFSR once; the pointer updates to the granted index.
REQ-021 In SERVE with req == 0, the LFSR and pointer SHALL hold and gnt SHALL be 0.
REQ-022 A seed handshake and a request in the same cycle: the seed SHALL win, and no gnt follows.
REQ-023 A seed handshake during WARMUP SHALL restart via LOAD with a full WARMUP count.
REQ-024 A single continuous requester SHALL receive a gnt every cycle, each with a distinct consecutive LFSR byte.
REQ-025 A req deasserted at edge k SHALL NOT cause a gnt at k+1.
REQ-026 Each LFSR state SHALL be delivered as prn at most once.

Reset
REQ-027 rst SHALL asynchronously set LFSR = DEFAULT_SEED, state = WARMUP, warmup counter = 0, pointer = NREQ-1, gnt = 0, prn = 8'h00.
REQ-028 After reset release, busy SHALL be 1 and seed_ready SHALL be 1 until WARMUP completes.
REQ-029 Reset asserted mid-grant SHALL clear gnt in the same cycle without waiting for a clock edge.

Structure
REQ-030 A shared package SHALL hold the state enum, the DEFAULT_SEED constant, the lockup constant 32'hFFFFFFFF and the tap-index list.
REQ-031 The LFSR SHALL be one sub-module, lfsr32_core (ports clk, rst, step, load, load_val, state, byte_out); arbitration and the FSM stay in prng_scheduler.

Verification
REQ-032 Reset, then req=4'b1111 held -> no gnt for 32 cycles; then gnt = 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
REQ-033 req=4'b0100 held in SERVE -> gnt = 0100 every cycle; prn matches the reference model stream with no repeats or skips.
REQ-034 seed=32'hFFFFFFFF accepted -> LOAD 1 cycle, busy 33 cycles; the following prn stream is identical to the post-reset stream.
REQ-035 seed=32'h00000001 accepted in the same cycle as req=4'b0011 -> no gnt next cycle; busy high 1+32 cycles; first gnt after that goes to the requester after the pointer.
REQ-036 rst pulsed mid-stream with req=4'b1000 -> gnt drops immediately; after 32 cycles the prn stream restarts from the DEFAULT_SEED sequence.
REQ-037 req=4'b1010 toggling every cycle -> gnt only for requests present at the prior edge; alternation 0010/1000 is preserved.

Source files
------------

// File: rtl/prng_scheduler_pkg.sv
// Shared types and constants for the PRNG scheduler and its LFSR core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prng_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SERVE  = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_SEED_C = 32'hBDCA2C92;

    // All-ones is the XNOR-feedback lockup state and must never be loaded.
    localparam logic [31:0] LOCKUP_C = 32'hFFFFFFFF;

    // LFSR bit feeding byte bit 7, 6, ... 0 in that order.
    localparam int TAP_IDX [8] = '{2, 3, 5, 7, 11, 13, 17, 23};

endpackage

// File: rtl/lfsr32_core.sv
// 32-bit XNOR Fibonacci LFSR with synchronous load and an 8-bit tap byte.
// Latency: step/load take effect at the next clock; byte_out is combinational from state.
// Backpressure: none; holds its value when neither step nor load is asserted.
module lfsr32_core
    import prng_scheduler_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] state,
    output logic [7:0]  byte_out
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Next state: load beats step; step shifts left with XNOR feedback into bit 0.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (step) begin
            state_d = {state_q[30:0], ~(state_q[31] ^ state_q[21] ^ state_q[1] ^ state_q[0])};
        end
    end

    // Tap byte is drawn from the current (pre-step) state.
    always_comb begin
        byte_out = 8'h00;
        for (int i = 0; i < 8; i++) begin
            byte_out[7-i] = state_q[TAP_IDX[i]];
        end
    end

    // State register with asynchronous reset to the seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/prng_scheduler.sv
// Round-robin scheduler handing one LFSR byte per grant to NREQ requesters, with reseed and warmup.
// Latency: a request seen at edge k is granted (gnt/prn) right after edge k+1 when in SERVE.
// Backpressure: busy is high outside SERVE; seed_ready drops only during the single LOAD cycle.
module prng_scheduler
    import prng_scheduler_pkg::*;
#(
    parameter int          NREQ         = 4,
    parameter int          WARMUP       = 32,
    parameter logic [31:0] DEFAULT_SEED = DEFAULT_SEED_C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [7:0]      prn,
    input  logic            seed_valid,
    input  logic [31:0]     seed,
    output logic            seed_ready,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      prn_q, prn_d;

    logic            seed_hs;
    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic            lfsr_step;
    logic            lfsr_load;
    logic [31:0]     lfsr_load_val;
    logic [31:0]     lfsr_state;
    logic [7:0]      lfsr_byte;

    assign seed_ready = (state_q != ST_LOAD);
    assign busy       = (state_q != ST_SERVE);
    assign seed_hs    = seed_valid && seed_ready;
    assign gnt        = gnt_q;
    assign prn        = prn_q;

    // Round-robin search: first active requester after the last granted index.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        for (int k = 1; k <= NREQ; k++) begin
            if (!pick_vld && req[(int'(ptr_q) + k) % NREQ]) begin
                pick_vld = 1'b1;
                pick_idx = PW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    // FSM next state, LFSR control and grant generation; a seed handshake overrides everything.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        gnt_d         = '0;
        prn_d         = prn_q;
        lfsr_step     = 1'b0;
        lfsr_load     = 1'b0;
        lfsr_load_val = (seed == LOCKUP_C) ? DEFAULT_SEED : seed;
        if (seed_hs) begin
            state_d   = ST_LOAD;
            lfsr_load = 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    cnt_d   = 8'd0;
                    state_d = ST_WARMUP;
                end
                ST_WARMUP: begin
                    lfsr_step = 1'b1;
                    if (cnt_q == 8'(WARMUP - 1)) begin
                        cnt_d   = 8'd0;
                        state_d = ST_SERVE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_SERVE: begin
                    if (pick_vld) begin
                        gnt_d[pick_idx] = 1'b1;
                        prn_d           = lfsr_byte;
                        lfsr_step       = 1'b1;
                        ptr_d           = pick_idx;
                    end
                end
                default: state_d = ST_WARMUP;
            endcase
        end
    end

    // Control registers; reset lands in WARMUP so the default seed is warmed up too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_WARMUP;
            cnt_q   <= 8'd0;
            ptr_q   <= PW'(NREQ - 1);
            gnt_q   <= '0;
            prn_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            prn_q   <= prn_d;
        end
    end

    lfsr32_core #(
        .SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (lfsr_step),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .state    (lfsr_state),
        .byte_out (lfsr_byte)
    );

    // The lockup substitution on load keeps the register out of the all-ones state.
    a_no_lockup: assert property (@(posedge clk) disable iff (rst) lfsr_state != LOCKUP_C);

endmodule

// File: tb/tb_prng_scheduler.sv
// Self-checking bench for prng_scheduler: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_prng_scheduler;

    localparam int          NREQ   = 4;
    localparam int          WARMUP = 32;
    localparam logic [31:0] DEF    = 32'hBDCA2C92;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic        seed_valid = 1'b0;
    logic [31:0] seed = 32'h0;
    logic [3:0]  gnt;
    logic [7:0]  prn;
    logic        seed_ready;
    logic        busy;

    always #5 clk = ~clk;

    prng_scheduler #(.NREQ(NREQ), .WARMUP(WARMUP), .DEFAULT_SEED(DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .prn        (prn),
        .seed_valid (seed_valid),
        .seed       (seed),
        .seed_ready (seed_ready),
        .busy       (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] f_step(input logic [31:0] l);
        logic fb;
        fb = ~(l[31] ^ l[21] ^ l[1] ^ l[0]);
        return (l << 1) | {31'b0, fb};
    endfunction

    function automatic logic [7:0] f_tap(input logic [31:0] l);
        return {l[2], l[3], l[5], l[7], l[11], l[13], l[17], l[23]};
    endfunction

    logic [31:0] m_lfsr;
    bit          m_load;
    int          m_warm;
    int          m_ptr;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_prn;
    bit          cmp_on = 1'b0;

    task automatic model_reset();
        m_lfsr  = DEF;
        m_load  = 1'b0;
        m_warm  = WARMUP;
        m_ptr   = NREQ - 1;
        exp_gnt = 4'b0000;
        exp_prn = 8'h00;
    endtask

    task automatic model_step();
        int idx;
        idx = -1;
        if (seed_valid && !m_load) begin
            m_lfsr  = (seed == 32'hFFFFFFFF) ? DEF : seed;
            m_load  = 1'b1;
            m_warm  = 0;
            exp_gnt = 4'b0000;
        end else if (m_load) begin
            m_load  = 1'b0;
            m_warm  = WARMUP;
            exp_gnt = 4'b0000;
        end else if (m_warm > 0) begin
            m_lfsr  = f_step(m_lfsr);
            m_warm  = m_warm - 1;
            exp_gnt = 4'b0000;
        end else if (req != 4'b0000) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (idx < 0 && req[(m_ptr + k) % NREQ]) idx = (m_ptr + k) % NREQ;
            end
            exp_gnt = 4'(1 << idx);
            exp_prn = f_tap(m_lfsr);
            m_lfsr  = f_step(m_lfsr);
            m_ptr   = idx;
        end else begin
            exp_gnt = 4'b0000;
        end
    endtask

    // Model advances on the same edges as the DUT, including asynchronous reset.
    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("gnt", 32'(gnt), 32'(exp_gnt));
            check("busy", 32'(busy), 32'(m_load || (m_warm > 0)));
            check("seed_ready", 32'(seed_ready), 32'(!m_load));
            if (exp_gnt != 4'b0000) check("prn", 32'(prn), 32'(exp_prn));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    logic [7:0] stream0 [5];
    logic [3:0] seq_exp [5];

    task automatic count_busy(input string nm, input int exp_n);
        int n;
        n = 0;
        while (busy && n < 200) begin
            n++;
            cyc();
        end
        check(nm, 32'(n), 32'(exp_n));
    endtask

    task automatic wait_gnt(input string nm, input int exp_n);
        int n;
        n = 0;
        while (gnt == 4'b0000 && n < 200) begin
            cyc();
            n++;
        end
        check(nm, 32'(n), 32'(exp_n));
    endtask

    task automatic compare_stream(input string nm);
        for (int i = 0; i < 5; i++) begin
            check(nm, 32'(prn), 32'(stream0[i]));
            cyc();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0100;
        seq_exp[3] = 4'b1000; seq_exp[4] = 4'b0001;

        // Model pins: XNOR feedback of all-zero is 1; all-ones is a fixed point; tap order.
        check("model_step_zero", f_step(32'h0000_0000), 32'h0000_0001);
        check("model_step_lockup", f_step(32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("model_tap_bit2", 32'(f_tap(32'h0000_0004)), 32'h80);
        check("model_tap_bit23", 32'(f_tap(32'h0080_0000)), 32'h01);

        // Reset values.
        rst = 1'b1;
        repeat (3) cyc();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_prn", 32'(prn), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_seed_ready", 32'(seed_ready), 32'h1);
        cmp_on = 1'b1;

        // All four requesting from reset: 32 warmup edges, then grants in order 0,1,2,3,0.
        req = 4'b1111;
        rst = 1'b0;
        wait_gnt("first_gnt_latency", WARMUP + 1);
        for (int i = 0; i < 5; i++) begin
            check("rr_sequence", 32'(gnt), 32'(seq_exp[i]));
            stream0[i] = prn;
            cyc();
        end

        // Lockup seed substitutes the default seed: same stream as after reset.
        seed = 32'hFFFF_FFFF;
        seed_valid = 1'b1;
        cyc();
        seed_valid = 1'b0;
        count_busy("lockup_busy_cycles", WARMUP + 1);
        wait_gnt("lockup_first_gnt", 1);
        compare_stream("lockup_stream");

        // Seed wins over a simultaneous request.
        req = 4'b0011;
        seed = 32'h0000_0001;
        seed_valid = 1'b1;
        cyc();
        seed_valid = 1'b0;
        check("seed_wins_no_gnt", 32'(gnt), 32'h0);
        count_busy("seed1_busy_cycles", WARMUP + 1);
        repeat (4) cyc();

        // Single continuous requester gets every cycle.
        req = 4'b0100;
        cyc();
        for (int i = 0; i < 20; i++) begin
            check("single_req_gnt", 32'(gnt), 32'h4);
            cyc();
        end

        // Toggling request: only requests present at the prior edge are granted.
        for (int i = 0; i < 20; i++) begin
            req = (i % 2 == 0) ? 4'b1010 : 4'b0000;
            cyc();
            if (i % 2 == 1) check("toggle_idle", 32'(gnt), 32'h0);
        end

        // Reset mid-grant: gnt drops without a clock edge; stream restarts.
        req = 4'b1000;
        cyc();
        cyc();
        check("pre_rst_gnt", 32'(gnt), 32'h8);
        rst = 1'b1;
        #1;
        check("rst_async_gnt", 32'(gnt), 32'h0);
        cyc();
        rst = 1'b0;
        wait_gnt("post_rst_latency", WARMUP + 1);
        compare_stream("post_rst_stream");

        // Randomized traffic with occasional reseeds, some of them the lockup value.
        for (int i = 0; i < 3000; i++) begin
            req = 4'($urandom);
            seed_valid = ($urandom_range(0, 39) == 0);
            seed = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            cyc();
        end
        seed_valid = 1'b0;
        req = 4'b0000;
        cyc();
        cmp_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
